// File: rtl/lut_ctrl_pkg.sv
// Shared types and helpers for the serial-load LUT controller.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package lut_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        VERIFY = 2'd2
    } lut_state_e;

    // Upper bounds for the generic entry extractor below.
    localparam int ENTRY_MAX_W = 32;
    localparam int IMAGE_MAX_W = 4096;
    localparam int IMAGE_IDX_W = $clog2(IMAGE_MAX_W);

    // Number of bits in a full table image.
    function automatic int table_bits(input int in_w, input int out_w);
        return (1 << in_w) * out_w;
    endfunction

    // Entry idx of a table image; entry i occupies bits [(i+1)*out_w-1 -: out_w].
    function automatic logic [ENTRY_MAX_W-1:0] tbl_entry(
        input logic [IMAGE_MAX_W-1:0] img,
        input int                     idx,
        input int                     out_w
    );
        logic [ENTRY_MAX_W-1:0] r;
        logic [IMAGE_IDX_W-1:0] pos;
        r = '0;
        for (int b = 0; b < ENTRY_MAX_W; b++) begin
            if (b < out_w) begin
                pos  = IMAGE_IDX_W'(idx * out_w + b);
                r[b] = img[pos];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/lut_load_ctrl_piso.sv
// Shadow register plus bit counter that streams a table image MSB first.
// Latency: first bit on d_o the cycle after load_i; cs_n_o low for exactly TABLE_BITS cycles.
// Backpressure: none; load_i must only be pulsed while idle (the controller guarantees it).
module lut_piso #(
    parameter int TABLE_BITS = 24,
    parameter int CNT_W      = $clog2(TABLE_BITS)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  load_i,
    input  logic [TABLE_BITS-1:0] data_i,
    output logic                  d_o,
    output logic                  cs_n_o,
`ifdef LUT_LOAD_CTRL_CHECK_EN
    output logic [TABLE_BITS-1:0] shadow_o,
`endif
    output logic                  done_o
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(TABLE_BITS - 1);
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(TABLE_BITS - 2);

    logic [TABLE_BITS-1:0] shadow_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  active_q;
    logic                  d_q;
    logic                  cs_n_q;
    logic [CNT_W-1:0]      nxt_idx_d;

    // Bit that goes out on the next shift cycle (counter cnt_q+1, MSB first).
    assign nxt_idx_d = PRE_LAST - cnt_q;

    // Latch the image and drive one bit per cycle; cs_n rises right after the last bit.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shadow_q <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
            d_q      <= 1'b0;
            cs_n_q   <= 1'b1;
        end else if (load_i) begin
            shadow_q <= data_i;
            cnt_q    <= '0;
            active_q <= 1'b1;
            d_q      <= data_i[TABLE_BITS-1];
            cs_n_q   <= 1'b0;
        end else if (active_q) begin
            if (cnt_q == LAST_BIT) begin
                cnt_q    <= '0;
                active_q <= 1'b0;
                d_q      <= 1'b0;
                cs_n_q   <= 1'b1;
            end else begin
                cnt_q <= cnt_q + 1'b1;
                d_q   <= shadow_q[nxt_idx_d];
            end
        end
    end

    assign d_o    = d_q;
    assign cs_n_o = cs_n_q;
    assign done_o = active_q && (cnt_q == LAST_BIT);
`ifdef LUT_LOAD_CTRL_CHECK_EN
    assign shadow_o = shadow_q;
`endif

endmodule

// File: rtl/lut_load_ctrl.sv
// Sequences table loads into a serial-load LUT and arbitrates its sel port with host lookups.
// Latency: load occupies TABLE_BITS+1 cycles (+2**IN_WIDTH+1 verify with LUT_LOAD_CTRL_CHECK_EN); lookup 2 cycles, 1/cycle.
// Backpressure: tbl_ready_o low while loading; lk_ready_o low unless idle with a good table and no load request.
module lut_load_ctrl
    import lut_ctrl_pkg::*;
#(
    parameter  int IN_WIDTH   = 3,
    parameter  int OUT_WIDTH  = 3,
    localparam int TABLE_BITS = table_bits(IN_WIDTH, OUT_WIDTH),
    localparam int CNT_W      = $clog2(TABLE_BITS)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [TABLE_BITS-1:0] tbl_data_i,
    input  logic                  tbl_valid_i,
    output logic                  tbl_ready_o,
    input  logic [IN_WIDTH-1:0]   lk_sel_i,
    input  logic                  lk_valid_i,
    output logic                  lk_ready_o,
    output logic [OUT_WIDTH-1:0]  lk_data_o,
    output logic                  lk_rvalid_o,
    output logic                  lut_d_o,
    output logic                  lut_cs_n_o,
    output logic [IN_WIDTH-1:0]   lut_sel_o,
    input  logic [OUT_WIDTH-1:0]  lut_out_i,
    output logic                  table_ok_o,
    output logic                  chk_err_o
);

    lut_state_e            state_q;
    logic                  tbl_ready_q;
    logic                  table_ok_q;
    logic [IN_WIDTH-1:0]   lut_sel_q;
    logic                  lk_pend_q;
    logic [OUT_WIDTH-1:0]  lk_data_q;
    logic                  lk_rvalid_q;
    logic                  tbl_acc_d;
    logic                  lk_acc_d;
    logic                  piso_done;

`ifdef LUT_LOAD_CTRL_CHECK_EN
    localparam int VCNT_W  = IN_WIDTH + 1;
    localparam int NUM_ENT = 2 ** IN_WIDTH;

    logic [VCNT_W-1:0]     vcnt_q;
    logic                  mis_q;
    logic                  chk_err_q;
    logic [TABLE_BITS-1:0] shadow;
    logic [OUT_WIDTH-1:0]  exp_entry;

    // Entry the LUT should be presenting for the currently driven select.
    assign exp_entry = OUT_WIDTH'(tbl_entry(IMAGE_MAX_W'(shadow), int'(lut_sel_q), OUT_WIDTH));
`endif

    // A pending load always beats a lookup in the same cycle.
    assign lk_ready_o = tbl_ready_q && table_ok_q && !tbl_valid_i;
    assign tbl_acc_d  = tbl_valid_i && tbl_ready_q;
    assign lk_acc_d   = lk_valid_i && lk_ready_o;

    lut_piso #(
        .TABLE_BITS (TABLE_BITS),
        .CNT_W      (CNT_W)
    ) u_piso (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load_i   (tbl_acc_d),
        .data_i   (tbl_data_i),
        .d_o      (lut_d_o),
        .cs_n_o   (lut_cs_n_o),
`ifdef LUT_LOAD_CTRL_CHECK_EN
        .shadow_o (shadow),
`endif
        .done_o   (piso_done)
    );

    // Control FSM: load acceptance, shift tracking, optional readback, and sel ownership.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            tbl_ready_q <= 1'b0;
            table_ok_q  <= 1'b0;
            lut_sel_q   <= '0;
            lk_pend_q   <= 1'b0;
`ifdef LUT_LOAD_CTRL_CHECK_EN
            vcnt_q      <= '0;
            mis_q       <= 1'b0;
            chk_err_q   <= 1'b0;
`endif
        end else begin
            lk_pend_q <= lk_acc_d;
            if (lk_acc_d) begin
                lut_sel_q <= lk_sel_i;
            end
            case (state_q)
                IDLE: begin
                    if (tbl_acc_d) begin
                        state_q     <= SHIFT;
                        tbl_ready_q <= 1'b0;
                        table_ok_q  <= 1'b0;
`ifdef LUT_LOAD_CTRL_CHECK_EN
                        chk_err_q   <= 1'b0;
`endif
                    end else begin
                        tbl_ready_q <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (piso_done) begin
`ifdef LUT_LOAD_CTRL_CHECK_EN
                        state_q   <= VERIFY;
                        vcnt_q    <= '0;
                        mis_q     <= 1'b0;
                        lut_sel_q <= '0;
`else
                        state_q     <= IDLE;
                        tbl_ready_q <= 1'b1;
                        table_ok_q  <= 1'b1;
`endif
                    end
                end
`ifdef LUT_LOAD_CTRL_CHECK_EN
                VERIFY: begin
                    vcnt_q <= vcnt_q + 1'b1;
                    if (vcnt_q < VCNT_W'(NUM_ENT)) begin
                        if (lut_out_i != exp_entry) begin
                            mis_q <= 1'b1;
                        end
                        if (vcnt_q < VCNT_W'(NUM_ENT - 1)) begin
                            lut_sel_q <= lut_sel_q + 1'b1;
                        end
                    end else begin
                        state_q     <= IDLE;
                        vcnt_q      <= '0;
                        tbl_ready_q <= 1'b1;
                        table_ok_q  <= !mis_q;
                        chk_err_q   <= mis_q;
                    end
                end
`endif
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Second lookup stage: capture the LUT output one cycle after sel was driven.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lk_data_q   <= '0;
            lk_rvalid_q <= 1'b0;
        end else begin
            lk_rvalid_q <= lk_pend_q;
            if (lk_pend_q) begin
                lk_data_q <= lut_out_i;
            end
        end
    end

    assign tbl_ready_o = tbl_ready_q;
    assign table_ok_o  = table_ok_q;
    assign lut_sel_o   = lut_sel_q;
    assign lk_data_o   = lk_data_q;
    assign lk_rvalid_o = lk_rvalid_q;
`ifdef LUT_LOAD_CTRL_CHECK_EN
    assign chk_err_o   = chk_err_q;
`else
    assign chk_err_o   = 1'b0;
`endif

endmodule
